pixel_fifo_stage: RTL and testbench
===================================

// Module: pixel_fifo_stage
// PURPOSE
//  Elastic buffer between colour LUT output (r,g,b + sof/eol sideband) and the stream packer.
//  Decouples variable-latency Mandelbrot depth calculation from packer/VDMA back-pressure.
//  Also checks line format on the write side.
//  Sits inside the pixel generator on the stream clock domain.
// PARAMETERS
//  DEPTH      16   FIFO entries; power of 2, >=4
//  AF_MARGIN  4    almost_full asserts when level >= DEPTH-AF_MARGIN
//  X_SIZE     640  pixels per line, used by the format checker (default from pixel_pkg)
// PORTS
//  aclk         in   1   stream clock; all logic on posedge
//  aresetn      in   1   asynchronous active-low reset
//  in_valid     in   1   upstream pixel valid
//  in_ready     out  1   FIFO accepts a pixel this cycle
//  in_r/g/b     in   8ea pixel colour
//  in_sof       in   1   first pixel of frame
//  in_eol       in   1   last pixel of line
//  out_valid    out  1   pixel available to the packer
//  out_ready    in   1   packer accepts the pixel
//  out_r/g/b    out  8ea head pixel colour
//  out_sof      out  1   head pixel sideband
//  out_eol      out  1   head pixel sideband
//  level        out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  almost_full  out  1   level >= DEPTH-AF_MARGIN (registered)
//  fmt_err      out  1   sticky line-format error
//  err_clr      in   1   synchronous clear of fmt_err
//  stall_cnt    out  32  starvation cycle count (see CONFIGURATION)
//  max_level    out  $clog2(DEPTH)+1  high-water mark (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert):
//   - Pointers, level, column counter, fmt_err, stall_cnt and max_level all go to 0.
//   - out_valid=0, almost_full=0, in_ready=0.
//   - in_ready rises on the first aclk edge after aresetn deasserts (registered rst_done flag).
//  Pointers:
//   - wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap flag.
//   - empty = ptrs equal. full = low bits equal and MSBs differ.
//   - Pointers wrap naturally modulo 2*DEPTH.
//  Handshake:
//   - push = in_valid & in_ready, where in_ready = rst_done & !full.
//   - pop  = out_valid & out_ready, where out_valid = !empty.
//   - Upstream must hold data stable while in_valid=1 and in_ready=0.
//  Output path:
//   - First-word-fall-through: out_* driven combinationally from mem[rd_ptr].
//   - Latency: pixel pushed at edge N is presented with out_valid=1 after edge N (cycle N+1).
//   - No same-cycle pass-through when empty.
//  Simultaneous push+pop:
//   - Allowed whenever neither full nor empty; level is unchanged.
//   - When full, in_ready=0, so no push even if pop occurs; in_ready rises the next cycle.
//   - When empty, no pop is possible.
//  Level arithmetic: level = wr_ptr - rd_ptr, computed modulo 2*DEPTH, width $clog2(DEPTH)+1.
//  Format checker (write side, on push only):
//   - col counts pushed pixels.
//   - Error if in_eol=1 with col != X_SIZE-1.
//   - Error if col == X_SIZE-1 with in_eol=0.
//   - Error if in_sof=1 with col != 0.
//   - Any error sets fmt_err.
//   - col returns to 0 after any eol push or at X_SIZE-1; otherwise col increments.
//   - Pixels are always stored, even when an error is flagged.
//   - err_clr=1 clears fmt_err; a same-cycle new error wins (fmt_err stays 1).
//  Reset mid-operation: contents are discarded, no partial pixel is emitted, and out_valid drops
//   asynchronously.
// CONFIGURATION
//  Macro PIXEL_FIFO_STATS_EN:
//   - Defined: stall_cnt increments (saturating at 2^32-1) every cycle where out_ready=1 and
//     out_valid=0. max_level updates to level whenever level > max_level. Both are cleared by
//     reset and by err_clr.
//   - Undefined: stall_cnt and max_level are tied to 0 and no counter logic is synthesised.
//   - Port list is identical in both cases.
// STRUCTURE
//  pixel_pkg:
//   - X_SIZE=640, Y_SIZE=480.
//   - typedef struct packed {logic [7:0] r,g,b; logic sof,eol;} pixel_t (26 bits).
//  Sub-module pixel_fifo_mem: DEPTH x pixel_t register array with one write port and one
//   asynchronous read port. Pointer, handshake, checker and stats logic live in the top.
// TESTING
//  1. Reset, then 16 pushes with out_ready=0 -> level=16, in_ready=0, almost_full=1 from level 12.
//     A 17th push is ignored.
//  2. Full FIFO, one pop -> in_ready=1 the next cycle. Drain order matches push order;
//     last pop gives out_valid=0 and level=0.
//  3. in_valid=1 and out_ready=1 continuously, from level 5 -> one pixel/cycle, level stays 5.
//     Data order is preserved across pointer wrap (>=40 pixels).
//  4. Line of 640 pixels with eol on pixel 639 -> fmt_err=0.
//     Next line with eol on pixel 100 -> fmt_err=1. err_clr pulse -> fmt_err=0.
//     The following 640-pixel line is clean.
//  5. Assert aresetn low with level=9 -> out_valid=0 and level=0 immediately.
//     After release, in_ready=1 on the first edge.
//  6. PIXEL_FIFO_STATS_EN defined; hold out_ready=1, keep FIFO empty 7 cycles, then fill to 11
//     -> stall_cnt=7, max_level=11. Macro undefined -> both read 0.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared pixel-stream types and frame geometry for the pixel generator.
package pixel_pkg;

    localparam int X_SIZE = 640;
    localparam int Y_SIZE = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sof;
        logic       eol;
    } pixel_t;

    // A pushed pixel breaks line format when eol and the last column disagree, or sof lands mid-line.
    function automatic logic line_fmt_err(input logic col_last, input logic col_zero,
                                          input logic sof, input logic eol);
        return (eol ^ col_last) | (sof & ~col_zero);
    endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// DEPTH x pixel_t register array: one synchronous write port, one asynchronous read port.
module pixel_fifo_mem
    import pixel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pixel_t        wdata,
    input  logic [AW-1:0] raddr,
    output pixel_t        rdata
);

    pixel_t r_mem [DEPTH];

    // Storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pixel_fifo_stage.sv
// Elastic FWFT pixel buffer with write-side line-format checker.
// Optional statistics counters are enabled by defining PIXEL_FIFO_STATS_EN.
module pixel_fifo_stage
    import pixel_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4,
    parameter int X_SIZE    = pixel_pkg::X_SIZE
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_r,
    input  logic [7:0]                 in_g,
    input  logic [7:0]                 in_b,
    input  logic                       in_sof,
    input  logic                       in_eol,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_r,
    output logic [7:0]                 out_g,
    output logic [7:0]                 out_b,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       fmt_err,
    input  logic                       err_clr,
    output logic [31:0]                stall_cnt,
    output logic [$clog2(DEPTH):0]     max_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(X_SIZE);

    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;
    logic          r_rst_done;
    logic          r_almost_full;
    logic          r_fmt_err;
    logic [CW-1:0] r_col;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level;
    logic [LW-1:0] w_level_next;
    logic          w_col_last;
    logic          w_line_err;
    logic [CW-1:0] w_col_next;
    logic          w_fmt_err_next;
    pixel_t        w_wr_pix;
    pixel_t        w_rd_pix;

    // The pointer MSB is a wrap flag: equal low bits with differing MSBs means full.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign in_ready  = r_rst_done & ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign level     = w_level;

    assign w_wr_pix  = {in_r, in_g, in_b, in_sof, in_eol};

    pixel_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (aclk),
        .we    (w_push),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (w_wr_pix),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_rd_pix)
    );

    assign out_r       = w_rd_pix.r;
    assign out_g       = w_rd_pix.g;
    assign out_b       = w_rd_pix.b;
    assign out_sof     = w_rd_pix.sof;
    assign out_eol     = w_rd_pix.eol;
    assign almost_full = r_almost_full;
    assign fmt_err     = r_fmt_err;

    assign w_col_last  = (r_col == CW'(X_SIZE - 1));
    assign w_line_err  = line_fmt_err(w_col_last, (r_col == {CW{1'b0}}), in_sof, in_eol);

    // Next occupancy, column and error state; a new error outranks err_clr.
    always_comb begin
        w_level_next   = w_level;
        w_col_next     = r_col;
        w_fmt_err_next = r_fmt_err;
        case ({w_push, w_pop})
            2'b10:   w_level_next = w_level + LW'(1);
            2'b01:   w_level_next = w_level - LW'(1);
            default: w_level_next = w_level;
        endcase
        if (w_push && (in_eol || w_col_last)) begin
            w_col_next = {CW{1'b0}};
        end else if (w_push) begin
            w_col_next = r_col + CW'(1);
        end else begin
            w_col_next = r_col;
        end
        if (w_push && w_line_err) begin
            w_fmt_err_next = 1'b1;
        end else if (err_clr) begin
            w_fmt_err_next = 1'b0;
        end else begin
            w_fmt_err_next = r_fmt_err;
        end
    end

    // Pointer, flag and checker state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr      <= {LW{1'b0}};
            r_rd_ptr      <= {LW{1'b0}};
            r_rst_done    <= 1'b0;
            r_almost_full <= 1'b0;
            r_fmt_err     <= 1'b0;
            r_col         <= {CW{1'b0}};
        end else begin
            r_rst_done    <= 1'b1;
            r_almost_full <= (w_level_next >= LW'(DEPTH - AF_MARGIN));
            r_fmt_err     <= w_fmt_err_next;
            r_col         <= w_col_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
            end
        end
    end

`ifdef PIXEL_FIFO_STATS_EN
    logic [31:0]   r_stall_cnt;
    logic [LW-1:0] r_max_level;

    // Starvation counter (saturating) and occupancy high-water mark.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stall_cnt <= 32'd0;
            r_max_level <= {LW{1'b0}};
        end else if (err_clr) begin
            r_stall_cnt <= 32'd0;
            r_max_level <= {LW{1'b0}};
        end else begin
            if (out_ready && !out_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_level > r_max_level) begin
                r_max_level <= w_level;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign max_level = r_max_level;
`else
    assign stall_cnt = 32'd0;
    assign max_level = {LW{1'b0}};
`endif

endmodule

// File: tb/tb_pixel_fifo_stage.sv
// Directed self-checking bench for pixel_fifo_stage (DEPTH=16, AF_MARGIN=4, X_SIZE=640).
module tb_pixel_fifo_stage;

    logic        aclk;
    logic        aresetn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r, in_g, in_b;
    logic        in_sof, in_eol;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_sof, out_eol;
    logic [4:0]  level;
    logic        almost_full;
    logic        fmt_err;
    logic        err_clr;
    logic [31:0] stall_cnt;
    logic [4:0]  max_level;

    int checks   = 0;
    int failures = 0;

    pixel_fifo_stage #(
        .DEPTH     (16),
        .AF_MARGIN (4),
        .X_SIZE    (640)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_r        (in_r),
        .in_g        (in_g),
        .in_b        (in_b),
        .in_sof      (in_sof),
        .in_eol      (in_eol),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .level       (level),
        .almost_full (almost_full),
        .fmt_err     (fmt_err),
        .err_clr     (err_clr),
        .stall_cnt   (stall_cnt),
        .max_level   (max_level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [25:0] pix(input int n, input logic sof, input logic eol);
        logic [7:0] v;
        v = n[7:0];
        return {v, ~v, v ^ 8'h5A, sof, eol};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [25:0] p);
        {in_r, in_g, in_b, in_sof, in_eol} = p;
    endtask

    task automatic release_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        step();
        chk("in_ready_first_edge", 64'(in_ready), 64'd1);
    endtask

    logic [25:0] head;
    assign head = {out_r, out_g, out_b, out_sof, out_eol};

    initial begin
        aresetn   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        drive(26'd0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_fmt_err", 64'(fmt_err), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_max_level", 64'(max_level), 64'd0);
        repeat (2) step();
        release_reset();

        // Fill to full with no reads.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            drive(pix(i, 1'b0, 1'b0));
            step();
            chk("fill_level", 64'(level), 64'(i + 1));
            chk("fill_almost_full", 64'(almost_full), 64'((i + 1) >= 12));
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(head), 64'(pix(0, 1'b0, 1'b0)));
        drive(pix(99, 1'b0, 1'b0));
        step();
        chk("push17_level", 64'(level), 64'd16);
        in_valid = 1'b0;

        // One pop from full, then drain in order.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop1_level", 64'(level), 64'd15);
        chk("pop1_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_head", 64'(head), 64'(pix(i, 1'b0, 1'b0)));
            step();
        end
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk("drained_level", 64'(level), 64'd0);
        chk("drained_almost_full", 64'(almost_full), 64'd0);
        out_ready = 1'b0;

        // Steady-state streaming at level 5 across pointer wrap.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            drive(pix(100 + k, 1'b0, 1'b0));
            step();
        end
        chk("stream_start_level", 64'(level), 64'd5);
        out_ready = 1'b1;
        for (int j = 0; j < 45; j++) begin
            drive(pix(105 + j, 1'b0, 1'b0));
            chk("stream_head", 64'(head), 64'(pix(100 + j, 1'b0, 1'b0)));
            step();
            chk("stream_level", 64'(level), 64'd5);
        end
        out_ready = 1'b0;
        chk("stream_head_after", 64'(head), 64'(pix(145, 1'b0, 1'b0)));
        for (int k = 0; k < 4; k++) begin
            drive(pix(150 + k, 1'b0, 1'b0));
            step();
        end
        in_valid = 1'b0;
        chk("pre_reset_level", 64'(level), 64'd9);
        chk("pre_reset_fmt_err", 64'(fmt_err), 64'd0);

        // Asynchronous reset mid-operation.
        aresetn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        release_reset();
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Line-format checker while streaming through.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 640; i++) begin
            drive(pix(i, (i == 0), (i == 639)));
            step();
        end
        chk("line_ok_fmt_err", 64'(fmt_err), 64'd0);
        for (int i = 0; i < 101; i++) begin
            drive(pix(i, (i == 0), (i == 100)));
            step();
            if (i == 99) chk("short_line_pre_err", 64'(fmt_err), 64'd0);
        end
        chk("short_line_fmt_err", 64'(fmt_err), 64'd1);
        in_valid = 1'b0;
        step();
        chk("fmt_err_sticky", 64'(fmt_err), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr_fmt_err", 64'(fmt_err), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 640; i++) begin
            drive(pix(i, (i == 0), (i == 639)));
            step();
        end
        chk("clean_line_fmt_err", 64'(fmt_err), 64'd0);
        drive(pix(7, 1'b0, 1'b1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_beats_clr", 64'(fmt_err), 64'd1);
        in_valid = 1'b0;
        step();
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Statistics: 7 starved cycles, then fill to 11.
        aresetn   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("stats_rst_fmt_err", 64'(fmt_err), 64'd0);
        release_reset();
        out_ready = 1'b1;
        repeat (7) step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 11; k++) begin
            drive(pix(200 + k, 1'b0, 1'b0));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stats_level", 64'(level), 64'd11);
        chk("stats_almost_full", 64'(almost_full), 64'd0);
`ifdef PIXEL_FIFO_STATS_EN
        chk("stats_stall_cnt", 64'(stall_cnt), 64'd7);
        chk("stats_max_level", 64'(max_level), 64'd11);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("stats_clr_stall", 64'(stall_cnt), 64'd0);
`else
        chk("stats_stall_cnt_off", 64'(stall_cnt), 64'd0);
        chk("stats_max_level_off", 64'(max_level), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
